// File: rtl/m_store_buffer_pkg.sv
// Shared widths and the entry payload type for the M-stage store buffer.
package m_store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_WORD  = 30;
  localparam int unsigned SB_BE    = 4;
  localparam int unsigned SB_DATA  = 32;

  // One posted store: word address, lane enables and lane-positioned data.
  typedef struct packed {
    logic [SB_WORD-1:0] word;
    logic [SB_BE-1:0]   byteen;
    logic [SB_DATA-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/m_store_buffer_sb_merge.sv
// Byte-lane merge of an incoming store into an existing entry.
module sb_merge
  import m_store_buffer_pkg::*;
(
  input  logic [SB_DATA-1:0] old_data,
  input  logic [SB_BE-1:0]   old_byteen,
  input  logic [SB_DATA-1:0] new_data,
  input  logic [SB_BE-1:0]   new_byteen,
  output logic [SB_DATA-1:0] merged_data,
  output logic [SB_BE-1:0]   merged_byteen
);

  // Incoming lanes overwrite, untouched lanes keep the old bytes.
  always_comb begin
    merged_data   = old_data;
    merged_byteen = old_byteen | new_byteen;
    for (int i = 0; i < int'(SB_BE); i++) begin
      if (new_byteen[i]) begin
        merged_data[8*i +: 8] = new_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/m_store_buffer.sv
// Posted-write FIFO between the M-stage byte-enable unit and the data-memory port,
// with tail merging of same-word stores and a pending-store load hit flag.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_addr,
  input  logic [3:0]               in_byteen,
  input  logic [31:0]              in_wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ld_check,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  output logic [3:0]               mem_byteen,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t         ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     tail_idx;

  logic              in_act;
  logic              merge;
  logic              push;
  logic              pop;
  logic [SB_DATA-1:0] merged_data;
  logic [SB_BE-1:0]   merged_byteen;
  sb_entry_t         head;
  logic              hit_any;
  logic              unused_lsb;

  // Byte-offset bits play no part in word matching.
  assign unused_lsb = ^{in_addr[1:0], ld_addr[1:0]};

  // Status is derived from the registered occupancy count only.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == CW'(0));
  assign mem_valid = !empty;

  // Push/merge/pop qualification; merge is judged against the pre-pop tail.
  assign tail_idx = wr_ptr - PW'(1);
  assign in_act   = in_valid && (in_byteen != 4'b0000);
  assign merge    = in_act && (count >= CW'(2)) && (in_addr[31:2] == ent_q[tail_idx].word);
  assign push     = in_act && !merge && !full;
  assign pop      = mem_valid && mem_ready;

  sb_merge u_merge (
    .old_data      (ent_q[tail_idx].data),
    .old_byteen    (ent_q[tail_idx].byteen),
    .new_data      (in_wdata),
    .new_byteen    (in_byteen),
    .merged_data   (merged_data),
    .merged_byteen (merged_byteen)
  );

  // Head presentation, forced to zero whenever nothing is pending.
  assign head       = ent_q[rd_ptr];
  assign mem_addr   = mem_valid ? {head.word, 2'b00} : 32'h0;
  assign mem_byteen = mem_valid ? head.byteen : 4'h0;
  assign mem_wdata  = mem_valid ? head.data : 32'h0;

  // Load hazard: any occupied entry holding the load's word.
  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] && (ent_q[i].word == ld_addr[31:2])) begin
        hit_any = 1'b1;
      end
    end
  end
  assign ld_hit = ld_check && hit_any;

  // Storage, valid bits, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ent_q[wr_ptr].word   <= in_addr[31:2];
        ent_q[wr_ptr].byteen <= in_byteen;
        ent_q[wr_ptr].data   <= in_wdata;
        vld_q[wr_ptr]        <= 1'b1;
        wr_ptr               <= wr_ptr + PW'(1);
      end
      if (merge) begin
        ent_q[tail_idx].byteen <= merged_byteen;
        ent_q[tail_idx].data   <= merged_data;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed self-checking bench for m_store_buffer.
module tb_m_store_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [3:0]  in_byteen;
  logic [31:0] in_wdata;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  int errors;
  int checks;

  m_store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_byteen  (in_byteen),
    .in_wdata   (in_wdata),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ld_check   (ld_check),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    in_valid  = v;
    in_addr   = a;
    in_byteen = be;
    in_wdata  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0; set_in(1'b0, 32'h0, 4'h0, 32'h0);
    mem_ready = 1'b0; ld_check = 1'b1; ld_addr = 32'h0;
    step(); step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got %b want 0", ld_hit); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({mem_addr, mem_byteen, mem_wdata} !== 68'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h/%h want 0", mem_addr, mem_byteen, mem_wdata); end
    ld_check = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_in(1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", mem_valid); end
    checks++; if (mem_addr !== 32'h0000_1004) begin errors++; $display("FAIL single_addr got %h want 00001004", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", mem_wdata); end
    checks++; if (mem_byteen !== 4'hF) begin errors++; $display("FAIL single_be got %h want f", mem_byteen); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    step();
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drain count=%0d empty=%b want 0/1", count, empty); end
    // Zero byte-enable store is ignored.
    set_in(1'b1, 32'h0000_1008, 4'h0, 32'h1234_5678);
    step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL zero_be_ignored empty=%b want 1", empty); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h0000_1000; exp_addr[1] = 32'h0000_2000;
    exp_addr[2] = 32'h0000_3000; exp_addr[3] = 32'h0000_4000;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, exp_addr[i], 4'hF, 32'hA000_0000 + 32'(i));
      step();
    end
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_full full=%b count=%0d want 1/4", full, count); end
    set_in(1'b1, 32'h0000_9000, 4'hF, 32'hBAD0_BAD0);
    step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (count !== 3'd4 || mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL fill_drop count=%0d addr=%h want 4/00001000", count, mem_addr); end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_addr !== exp_addr[i] || mem_wdata !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL fill_order%0d addr=%h data=%h want %h/%h", i, mem_addr, mem_wdata, exp_addr[i], 32'hA000_0000 + 32'(i)); end
      if (i == 0) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_before_pop got %b want 1", full); end
      end
      step();
      if (i == 0) begin
        checks++; if (full !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL fill_full_after_pop full=%b count=%0d want 0/3", full, count); end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained empty=%b want 1", empty); end
  endtask

  task automatic test_merge();
    mem_ready = 1'b0;
    set_in(1'b1, 32'h0000_0100, 4'b0001, 32'h0000_00AA); step();
    set_in(1'b1, 32'h0000_0200, 4'b0001, 32'h0000_0011); step();
    set_in(1'b1, 32'h0000_0200, 4'b0100, 32'h0022_0000); step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL merge_count got %0d want 2", count); end
    checks++; if (mem_addr !== 32'h100 || mem_byteen !== 4'b0001 || mem_wdata !== 32'hAA) begin errors++; $display("FAIL merge_head got %h/%b/%h want 100/0001/aa", mem_addr, mem_byteen, mem_wdata); end
    mem_ready = 1'b1;
    step();
    checks++; if (mem_addr !== 32'h200 || mem_byteen !== 4'b0101 || mem_wdata !== 32'h0022_0011) begin errors++; $display("FAIL merge_tail got %h/%b/%h want 200/0101/00220011", mem_addr, mem_byteen, mem_wdata); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL merge_drained empty=%b want 1", empty); end
  endtask

  task automatic test_no_merge_head();
    mem_ready = 1'b0;
    set_in(1'b1, 32'h0000_0300, 4'hF, 32'h1111_1111); step();
    set_in(1'b1, 32'h0000_0300, 4'b0010, 32'h0000_2200); step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL nohead_count got %0d want 2", count); end
    checks++; if (mem_addr !== 32'h300 || mem_byteen !== 4'hF || mem_wdata !== 32'h1111_1111) begin errors++; $display("FAIL nohead_head got %h/%b/%h want 300/1111/11111111", mem_addr, mem_byteen, mem_wdata); end
    mem_ready = 1'b1;
    step();
    checks++; if (mem_addr !== 32'h300 || mem_byteen !== 4'b0010 || mem_wdata !== 32'h0000_2200) begin errors++; $display("FAIL nohead_second got %h/%b/%h want 300/0010/00002200", mem_addr, mem_byteen, mem_wdata); end
    step();
  endtask

  task automatic test_merge_pop();
    mem_ready = 1'b0;
    set_in(1'b1, 32'h0000_0400, 4'hF, 32'h4444_4444); step();
    set_in(1'b1, 32'h0000_0500, 4'b0001, 32'h0000_0055); step();
    mem_ready = 1'b1;
    set_in(1'b1, 32'h0000_0500, 4'b1000, 32'h6600_0000); step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL mergepop_count got %0d want 1", count); end
    checks++; if (mem_addr !== 32'h500 || mem_byteen !== 4'b1001 || mem_wdata !== 32'h6600_0055) begin errors++; $display("FAIL mergepop_head got %h/%b/%h want 500/1001/66000055", mem_addr, mem_byteen, mem_wdata); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mergepop_drained empty=%b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h0000_7000 + 32'(i * 16), 4'hF, 32'hC0DE_0000 + 32'(i));
      step();
      checks++; if (count !== 3'd1 || mem_addr !== 32'h0000_7000 + 32'(i * 16)) begin errors++; $display("FAIL b2b_%0d count=%0d addr=%h want 1/%h", i, count, mem_addr, 32'h0000_7000 + 32'(i * 16)); end
    end
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drained empty=%b want 1", empty); end
  endtask

  task automatic test_load_hit();
    mem_ready = 1'b0;
    set_in(1'b1, 32'h0000_2008, 4'hF, 32'h5555_AAAA); step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    ld_check = 1'b1; ld_addr = 32'h0000_200B; #1;
    checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL ldhit_same_word got %b want 1", ld_hit); end
    ld_addr = 32'h0000_200C; #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ldhit_next_word got %b want 0", ld_hit); end
    ld_check = 1'b0; ld_addr = 32'h0000_2008; #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ldhit_no_check got %b want 0", ld_hit); end
  endtask

  task automatic test_reset_mid();
    // Entry at 0x2008 still pending from the load-hit scenario.
    set_in(1'b1, 32'h0000_3000, 4'hF, 32'h3333_3333); step();
    set_in(1'b1, 32'h0000_4000, 4'hF, 32'h4444_4444); step();
    set_in(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (count !== 3'd3 || mem_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup count=%0d valid=%b want 3/1", count, mem_valid); end
    ld_check = 1'b1; ld_addr = 32'h0000_2008;
    #2 reset = 1'b0; #1;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || mem_valid !== 1'b0 || ld_hit !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL midrst_status empty=%b full=%b valid=%b hit=%b count=%0d want 1/0/0/0/0", empty, full, mem_valid, ld_hit, count); end
    checks++; if ({mem_addr, mem_byteen, mem_wdata} !== 68'h0) begin errors++; $display("FAIL midrst_bus got %h/%h/%h want 0", mem_addr, mem_byteen, mem_wdata); end
    step();
    reset = 1'b1; ld_check = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL midrst_after%0d valid=%b empty=%b want 0/1", i, mem_valid, empty); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_fill();
    test_merge();
    test_no_merge_head();
    test_merge_pop();
    test_back_to_back();
    test_load_hit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_store_buffer.md
# m_store_buffer

Posted-write buffer between the M-stage byte-enable unit and the data-memory bus port. It accepts already-aligned stores (word address, 4-bit byte enable, lane-positioned write data) and queues them in a small FIFO. It drains them to memory over a valid/ready handshake, merging consecutive stores to the same word. It also flags loads that touch a word with a pending store, so the hazard unit can stall those loads.

## Interface
- DEPTH, 4: number of entries; power of two, minimum 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  store presented by the M-stage byte-enable unit this cycle.
- in_addr  input  32  store byte address; bits [1:0] are ignored.
- in_byteen  input  4  byte lanes to write, already positioned.
- in_wdata  input  32  write data, already lane-aligned.
- full  output  1  no free entry; upstream must stall the store.
- empty  output  1  no pending entries.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- ld_check  input  1  a load is in M this cycle.
- ld_addr  input  32  load byte address.
- ld_hit  output  1  the load word matches a pending entry.
- mem_valid  output  1  head entry is presented to memory.
- mem_addr  output  32  head word address, with {addr[31:2], 2'b00}.
- mem_byteen  output  4  head byte enables.
- mem_wdata  output  32  head write data.
- mem_ready  input  1  memory accepts the head entry this cycle.

## Operation
- Entry fields: word address [31:2], byteen[3:0], data[31:0].
- Push qualification:
  - A push requires in_valid=1, in_byteen≠0 and no merge.
  - in_valid with in_byteen=0 is ignored.
  - A push while full=1 is dropped, with no state change. Upstream honours full.
- Merge:
  - Merge applies when in_valid=1, in_byteen≠0, count≥2, and in_addr[31:2] equals the tail entry word.
  - The tail byteen becomes the OR of the old and incoming byteen.
  - For each lane i with in_byteen[i]=1, the tail data byte i becomes in_wdata byte i. Other lanes are kept.
  - count is unchanged by a merge.
  - The head entry is never merged into, because it is already presented.
- Pop: a pop occurs when mem_valid=1 and mem_ready=1.
- Push and pop in the same cycle leave count unchanged.
- A merge and a pop in the same cycle are both applied.
- A merge is evaluated against the tail as it stood before the pop. A merge with count=2 and a simultaneous pop is still legal, because the tail is not the head.
- mem_valid = !empty. The head fields stay stable while mem_valid=1 and mem_ready=0.
- ld_hit = ld_check AND (some occupied entry has word == ld_addr[31:2]).
  - This is combinational over occupied entries only; the store presented at in_* this cycle is not checked.
  - An entry being popped this cycle still counts.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is the authoritative full/empty source: full = (count==DEPTH), empty = (count==0).

## Timing
- Reset (asynchronous, active-low) clears:
  - all pointers;
  - count to 0;
  - all entry valid bits.
- Output values during and after reset:
  - empty=1, full=0, mem_valid=0, ld_hit=0;
  - mem_addr, mem_byteen and mem_wdata all 0.
- Reset asserted mid-handshake discards every pending entry. No partial write is reissued.
- Latency from empty: a push at edge N gives mem_valid=1 after edge N. The earliest accepting mem_ready is in cycle N+1.
- Throughput is one push and one pop per cycle.
- full and empty are registered-state derived, so there is no combinational path from in_valid.
- Combinational paths to ld_hit exist only from ld_check and ld_addr.
- mem_ready→full has no combinational path. A full buffer frees an entry one cycle after the pop.

## Structure
- def.v gains:
  - `SB_DEPTH (default 4);
  - `SB_WORD (width 30) for the entry word-address width.
- The BE encodings stay where they are; this block consumes positioned byteen only.
- One sub-module, sb_merge: combinational lane merge of old data/byteen with new data/byteen, producing the merged data and byteen.
- The FIFO storage, pointers, count and hit compare stay in m_store_buffer.

## Test plan
- **Single store:** reset, then push addr 0x0000_1004, byteen 4'b1111, data 0xDEAD_BEEF with mem_ready=1.
  - mem_valid rises next cycle with mem_addr 0x0000_1004 and data 0xDEAD_BEEF.
  - The pop returns count to 0 and sets empty=1.
- **Fill and stall:** with mem_ready=0, push DEPTH distinct words.
  - full=1 and count=4.
  - A fifth push is dropped.
  - Raise mem_ready: entries drain in order, and full falls one cycle after the first pop.
- **Merge:**
  - mem_ready=0; push word 0x100 byteen 0001 data 0x0000_00AA.
  - Push word 0x200 byteen 0001 data 0x0000_0011.
  - Push word 0x200 byteen 0100 data 0x0022_0000.
  - Expected: count=2, tail byteen 0101, data 0x0022_0011.
- **No merge into head:** count=1 at word 0x300 and mem_ready=0; push word 0x300 byteen 0010.
  - A new entry is created, count=2.
  - The head stays unchanged.
- **Load hit:** pending word 0x0000_2008.
  - ld_check=1 with ld_addr 0x0000_200B gives ld_hit=1.
  - ld_addr 0x0000_200C gives ld_hit=0.
  - ld_check=0 gives ld_hit=0.
- **Reset mid-operation:** 3 entries pending with mem_valid=1 and mem_ready=0; assert reset.
  - All outputs go to their reset values immediately.
  - After release, empty=1 and no memory write occurs.
